// File: rtl/tuart_tx_cfg_pkg.sv
// Shared types for the configurable Tiny-UART transmitter:
// parity mode, transmitter state, flow-control state and parity helpers.
package tuart_tx_cfg_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PAUSE
    } tuart_tx_state_t;

    typedef enum logic {
        XC_XON  = 1'b0,
        XC_XOFF = 1'b1
    } xcrtl_t;

    // Raw code 3 has no meaning and falls back to no parity.
    function automatic parity_t par_decode(logic [1:0] p);
        return (p == 2'd3) ? PAR_NONE : parity_t'(p);
    endfunction

    // xr is the XOR reduction of the data word.
    function automatic logic par_bit(parity_t p, logic xr);
        return (p == PAR_ODD) ? ~xr : xr;
    endfunction

endpackage

// File: rtl/tuart_tx_cfg_if.sv
// Command/flow-control/serial bundle of the configurable UART transmitter.
// master drives stb/data/sel/div/par/stop2/xstb/xon/xoff; slave drives rdy/tx/paused/wdone.
interface tuart_tx_cfg_if #(
    parameter int WORD_BITS = 8,
    parameter int CMD_WORDS = 4,
    parameter int DIV_BITS  = 16
);
    import tuart_tx_cfg_pkg::*;

    logic                           stb_i;
    logic                           rdy_o;
    logic [WORD_BITS*CMD_WORDS-1:0] data_i;
    logic [$clog2(CMD_WORDS):0]     sel_i;
    logic [DIV_BITS-1:0]            div_i;
    logic [1:0]                     par_i;
    logic                           stop2_i;
    logic                           xstb_i;
    logic                           xon_i;
    logic                           xoff_i;
    logic                           tx_o;
    logic                           paused_o;
    logic                           wdone_o;

    modport master (
        output stb_i, data_i, sel_i, div_i, par_i, stop2_i,
        output xstb_i, xon_i, xoff_i,
        input  rdy_o, tx_o, paused_o, wdone_o
    );

    modport slave (
        input  stb_i, data_i, sel_i, div_i, par_i, stop2_i,
        input  xstb_i, xon_i, xoff_i,
        output rdy_o, tx_o, paused_o, wdone_o
    );

endinterface

// File: rtl/tuart_tx_cfg_baud_tick.sv
// Bit-period timer: loadable down-counter, tick_o on the last clock of each bit.
// Ports: clk_i, rst_in, restart_i (load div_i-1), en_i (count), div_i (>=1), tick_o.
module tuart_baud_tick #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_in,
    input  logic                restart_i,
    input  logic                en_i,
    input  logic [DIV_BITS-1:0] div_i,
    output logic                tick_o
);

    logic [DIV_BITS-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= div_i - DIV_BITS'(1);
        end else if (en_i) begin
            // Self-reload so back-to-back bits need no restart.
            cnt_q <= (cnt_q == '0) ? div_i - DIV_BITS'(1)
                                   : cnt_q - DIV_BITS'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/tuart_tx_cfg.sv
// Runtime-configurable UART transmitter: 1..CMD_WORDS words per strobe, XON/XOFF between words.
// Ports: clk_i, rst_in (async, active-low), bus (slave side of tuart_tx_cfg_if).
module tuart_tx_cfg
    import tuart_tx_cfg_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int CMD_WORDS = 4,
    parameter int DIV_BITS  = 16
) (
    input  logic          clk_i,
    input  logic          rst_in,
    tuart_tx_cfg_if.slave bus
);

    localparam int MW = WORD_BITS * CMD_WORDS;
    localparam int SW = $clog2(CMD_WORDS) + 1;
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam int WW = $clog2(CMD_WORDS + 1);

    tuart_tx_state_t     state_q, state_n;
    xcrtl_t              xc_q;
    parity_t             par_q, par_n;
    logic                stop2_q, stop2_n;
    logic [DIV_BITS-1:0] div_q, div_n;
    logic [WORD_BITS-1:0] sh_q, sh_n;
    logic [MW-1:0]       msg_q, msg_n;
    logic                pbit_q, pbit_n;
    logic [BW-1:0]       bcnt_q, bcnt_n;
    logic [WW-1:0]       wcnt_q, wcnt_n;
    logic                tx_q, tx_n;
    logic                rdy, paused, wdone;
    logic                xon, accept, tick, run, restart;
    logic                last_bit, last_stop, last_word;

    assign xon       = (xc_q == XC_XON);
    assign accept    = (state_q == IDLE) && xon && bus.stb_i
                       && (bus.sel_i != '0);
    assign last_bit  = (bcnt_q == BW'(WORD_BITS - 1));
    assign last_stop = !stop2_q || (bcnt_q == BW'(1));
    assign last_word = (wcnt_q == WW'(1));
    assign run       = state_q inside {START, DATA, PARITY, STOP};
    assign restart   = accept || ((state_q == PAUSE) && xon);

    // Frame settings are captured at accept and frozen until IDLE.
    assign div_n   = accept ? ((bus.div_i == '0) ? DIV_BITS'(1) : bus.div_i)
                            : div_q;
    assign par_n   = accept ? par_decode(bus.par_i) : par_q;
    assign stop2_n = accept ? bus.stop2_i : stop2_q;

    tuart_baud_tick #(
        .DIV_BITS (DIV_BITS)
    ) u_baud (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .restart_i (restart),
        .en_i      (run),
        .div_i     (div_n),
        .tick_o    (tick)
    );

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            xc_q <= XC_XON;
        end else if (bus.xstb_i) begin
            if (bus.xon_i) begin
                xc_q <= XC_XON;
            end else if (bus.xoff_i) begin
                xc_q <= XC_XOFF;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_n = START;
            START:   if (tick) state_n = DATA;
            DATA: begin
                if (tick && last_bit) begin
                    state_n = (par_q != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY:  if (tick) state_n = STOP;
            STOP: begin
                if (tick && last_stop) begin
                    if (last_word) begin
                        state_n = IDLE;
                    end else begin
                        state_n = xon ? START : PAUSE;
                    end
                end
            end
            PAUSE:   if (xon) state_n = START;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: word shifter, message buffer, bit/stop and word counters.
    always_comb begin
        sh_n   = sh_q;
        msg_n  = msg_q;
        pbit_n = pbit_q;
        bcnt_n = bcnt_q;
        wcnt_n = wcnt_q;
        if (accept) begin
            sh_n   = bus.data_i[WORD_BITS-1:0];
            msg_n  = bus.data_i >> WORD_BITS;
            pbit_n = par_bit(par_n, ^bus.data_i[WORD_BITS-1:0]);
            bcnt_n = '0;
            wcnt_n = (bus.sel_i > SW'(CMD_WORDS)) ? WW'(CMD_WORDS)
                                                  : WW'(bus.sel_i);
        end else if (tick) begin
            unique case (state_q)
                DATA: begin
                    sh_n   = sh_q >> 1;
                    bcnt_n = last_bit ? '0 : bcnt_q + BW'(1);
                end
                STOP: begin
                    if (!last_stop) begin
                        bcnt_n = bcnt_q + BW'(1);
                    end else begin
                        bcnt_n = '0;
                        if (!last_word) begin
                            wcnt_n = wcnt_q - WW'(1);
                            sh_n   = msg_q[WORD_BITS-1:0];
                            msg_n  = msg_q >> WORD_BITS;
                            pbit_n = par_bit(par_q,
                                             ^msg_q[WORD_BITS-1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            div_q   <= '0;
            sh_q    <= '0;
            msg_q   <= '0;
            pbit_q  <= 1'b0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            par_q   <= par_n;
            stop2_q <= stop2_n;
            div_q   <= div_n;
            sh_q    <= sh_n;
            msg_q   <= msg_n;
            pbit_q  <= pbit_n;
            bcnt_q  <= bcnt_n;
            wcnt_q  <= wcnt_n;
            tx_q    <= tx_n;
        end
    end

    // tx_n looks at the next state so the line changes on the bit edge.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            PARITY:  tx_n = pbit_n;
            default: tx_n = 1'b1;
        endcase
        rdy    = (state_q == IDLE) && xon;
        paused = (state_q == PAUSE);
        wdone  = (state_q == STOP) && tick && last_stop;
    end

    assign bus.tx_o     = tx_q;
    assign bus.rdy_o    = rdy;
    assign bus.paused_o = paused;
    assign bus.wdone_o  = wdone;

endmodule

// File: tb/tb_tuart_tx_cfg.sv
// Self-checking bench for tuart_tx_cfg: per-cycle compare against a
// bit-sample queue model, plus directed literal expectations.
module tb_tuart_tx_cfg;

    localparam int WB = 8;
    localparam int CW = 4;
    localparam int DB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    tuart_tx_cfg_if #(
        .WORD_BITS (WB),
        .CMD_WORDS (CW),
        .DIV_BITS  (DB)
    ) bus ();

    tuart_tx_cfg #(
        .WORD_BITS (WB),
        .CMD_WORDS (CW),
        .DIV_BITS  (DB)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: each word expands into a queue of per-clock line samples.
    bit             m_xon    = 1'b1;
    bit             m_paused = 1'b0;
    bit             m_wave[$];
    logic [WB-1:0]  m_words[$];
    int             m_d      = 1;
    int             m_par    = 0;
    bit             m_stop2  = 1'b0;

    task automatic m_load();
        logic [WB-1:0] w;
        bit            b[$];
        w = m_words.pop_front();
        b.push_back(1'b0);
        for (int i = 0; i < WB; i++) b.push_back(w[i]);
        if (m_par == 1) b.push_back(^w);
        else if (m_par == 2) b.push_back(~^w);
        b.push_back(1'b1);
        if (m_stop2) b.push_back(1'b1);
        foreach (b[i]) repeat (m_d) m_wave.push_back(b[i]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            m_xon    = 1'b1;
            m_paused = 1'b0;
            m_wave.delete();
            m_words.delete();
        end else begin
            if (m_wave.size() != 0) begin
                void'(m_wave.pop_front());
                if (m_wave.size() == 0 && m_words.size() != 0) begin
                    if (m_xon) m_load();
                    else m_paused = 1'b1;
                end
            end else if (m_paused) begin
                if (m_xon) begin
                    m_paused = 1'b0;
                    m_load();
                end
            end else if (bus.stb_i && m_xon && bus.sel_i != 0) begin
                n       = (int'(bus.sel_i) > CW) ? CW : int'(bus.sel_i);
                m_d     = (bus.div_i == 0) ? 1 : int'(bus.div_i);
                m_par   = (bus.par_i == 2'd3) ? 0 : int'(bus.par_i);
                m_stop2 = bus.stop2_i;
                for (int i = 0; i < n; i++)
                    m_words.push_back(bus.data_i[i*WB +: WB]);
                m_load();
            end
            if (bus.xstb_i) begin
                if (bus.xon_i) m_xon = 1'b1;
                else if (bus.xoff_i) m_xon = 1'b0;
            end
        end
    end

    int   cyc = 0;
    logic tx_log [int];
    int   wd_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            tx_log[cyc] = bus.tx_o;
            if (bus.wdone_o) wd_t.push_back(cyc);
            chk("tx", bus.tx_o, (m_wave.size() != 0) ? m_wave[0] : 1'b1);
            chk("wdone", bus.wdone_o, m_wave.size() == 1);
            chk("paused", bus.paused_o, m_paused);
            chk("rdy", bus.rdy_o,
                m_wave.size() == 0 && !m_paused && m_xon);
        end
    end

    // Called just after a negedge; returns the cycle index of clk 1.
    task automatic send(input logic [31:0] d, input int sel,
                        input int div, input int par, input bit s2,
                        output int a);
        bus.data_i  = d;
        bus.sel_i   = 3'(sel);
        bus.div_i   = DB'(div);
        bus.par_i   = 2'(par);
        bus.stop2_i = s2;
        bus.stb_i   = 1'b1;
        @(negedge clk);
        a = cyc;
        bus.stb_i   = 1'b0;
        bus.data_i  = $urandom;
        bus.sel_i   = 3'($urandom_range(0, 7));
        bus.div_i   = DB'($urandom_range(1, 9));
        bus.par_i   = 2'($urandom_range(0, 3));
        bus.stop2_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!bus.rdy_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", bus.rdy_o, 1);
    endtask

    task automatic xpulse(input bit on, input bit off);
        bus.xstb_i = 1'b1;
        bus.xon_i  = on;
        bus.xoff_i = off;
        @(negedge clk);
        bus.xstb_i = 1'b0;
        bus.xon_i  = 1'b0;
        bus.xoff_i = 1'b0;
    endtask

    function automatic int wd_at(input int i, input int a);
        return (wd_t.size() > i) ? wd_t[i] - a + 1 : -1;
    endfunction

    initial begin
        int         a;
        logic [9:0] exp1;
        bus.stb_i   = 1'b0;
        bus.data_i  = '0;
        bus.sel_i   = '0;
        bus.div_i   = '0;
        bus.par_i   = '0;
        bus.stop2_i = 1'b0;
        bus.xstb_i  = 1'b0;
        bus.xon_i   = 1'b0;
        bus.xoff_i  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx", bus.tx_o, 1);
        chk("rst_rdy", bus.rdy_o, 1);
        chk("rst_paused", bus.paused_o, 0);
        chk("rst_wdone", bus.wdone_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, D=4, 0x55
        wd_t.delete();
        send(32'h55, 1, 4, 0, 1'b0, a);
        wait_idle(100);
        exp1 = 10'b10_1010_1010;
        for (int b = 0; b < 10; b++)
            chk("t1_bit", tx_log[a + b*4 + 1], exp1[b]);
        chk("t1_nwd", wd_t.size(), 1);
        chk("t1_wd40", wd_at(0, a), 40);

        // parity, D=3, 0x07
        wd_t.delete();
        send(32'h07, 1, 3, 1, 1'b0, a);
        wait_idle(100);
        chk("t2_even", tx_log[a + 28], 1);
        chk("t2_even_len", wd_at(0, a), 33);
        wd_t.delete();
        send(32'h07, 1, 3, 2, 1'b0, a);
        wait_idle(100);
        chk("t2_odd", tx_log[a + 28], 0);
        wd_t.delete();
        send(32'h07, 1, 3, 1, 1'b1, a);
        wait_idle(100);
        chk("t2_stop2_len", wd_at(0, a), 36);

        // three words back to back
        wd_t.delete();
        send(32'h00CC_BBAA, 3, 2, 0, 1'b0, a);
        wait_idle(200);
        chk("t3_nwd", wd_t.size(), 3);
        chk("t3_wd0", wd_at(0, a), 20);
        chk("t3_gap1", wd_at(1, a) - wd_at(0, a), 20);
        chk("t3_gap2", wd_at(2, a) - wd_at(1, a), 20);
        chk("t3_w1_start", tx_log[a + 20], 0);
        chk("t3_w1_b0", tx_log[a + 22], 1);

        // XOFF during word 0
        wd_t.delete();
        send(32'h0033_2211, 3, 2, 0, 1'b0, a);
        repeat (3) @(negedge clk);
        xpulse(1'b0, 1'b1);
        begin
            int k = 0;
            while (!bus.paused_o && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t4_paused", bus.paused_o, 1);
        chk("t4_tx_idle", bus.tx_o, 1);
        chk("t4_w0_done", wd_t.size(), 1);
        repeat (50) @(negedge clk);
        chk("t4_hold", bus.paused_o, 1);
        xpulse(1'b1, 1'b0);
        chk("t4_xon_reg", bus.paused_o, 1);
        @(negedge clk);
        chk("t4_start", bus.tx_o, 0);
        chk("t4_unpaused", bus.paused_o, 0);
        wait_idle(200);
        chk("t4_nwd", wd_t.size(), 3);

        // XOFF in IDLE blocks the strobe
        wd_t.delete();
        xpulse(1'b0, 1'b1);
        chk("t5_rdy_off", bus.rdy_o, 0);
        send(32'h12, 1, 1, 0, 1'b0, a);
        repeat (15) @(negedge clk);
        chk("t5_ignored", wd_t.size(), 0);
        chk("t5_ign_tx", bus.tx_o, 1);
        xpulse(1'b1, 1'b1);
        chk("t5_xon_wins", bus.rdy_o, 1);

        // sel=0 is ignored
        send(32'h34, 0, 1, 0, 1'b0, a);
        repeat (15) @(negedge clk);
        chk("t5_sel0", wd_t.size(), 0);
        chk("t5_sel0_rdy", bus.rdy_o, 1);

        // sel=7 clamps to four words
        wd_t.delete();
        send(32'h4433_2211, 7, 1, 0, 1'b0, a);
        wait_idle(200);
        chk("t5_clamp", wd_t.size(), 4);
        chk("t5_clamp_len", wd_at(3, a), 40);

        // async reset mid-DATA
        wd_t.delete();
        send(32'h00, 1, 5, 0, 1'b0, a);
        repeat (12) @(negedge clk);
        chk("t6_pre_rst", bus.tx_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", bus.tx_o, 1);
        chk("t6_rst_rdy", bus.rdy_o, 1);
        chk("t6_rst_paused", bus.paused_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t6_no_wdone", wd_t.size(), 0);

        // div=0 behaves as 1 clk per bit
        wd_t.delete();
        send(32'hA5, 1, 0, 0, 1'b0, a);
        wait_idle(50);
        chk("t6_div0_len", wd_at(0, a), 10);
        chk("t6_div0_b1", tx_log[a + 1], 1);
        chk("t6_div0_b2", tx_log[a + 2], 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
